// File: rtl/booth_mul_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : booth_mul_seq_if
//  Description : Operand/result handshake bundle for the sequential Booth
//                multiplier.
//                master : issue/writeback side (drives operands, out_ready)
//                slave  : multiplier side (drives in_ready, result, busy)
//                Signals: in_valid, in_ready, a, b, is_signed,
//                         out_valid, out_ready, result, busy
//  Revision    : 1.0 - initial release
// ============================================================================
interface booth_mul_seq_if #(
    parameter int WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 is_signed;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic                 busy;

    modport master (
        output in_valid, a, b, is_signed, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, a, b, is_signed, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface
`default_nettype wire

// File: rtl/booth_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : booth_mul_seq
//  Description : Parametrised sequential Booth multiplier, one Booth digit
//                retired per clock, signed/unsigned selectable per operation.
//                Ports:
//                  clk  - clock, rising edge
//                  rst  - synchronous active-high reset
//                  bus  - booth_mul_seq_if.slave (operand/result handshakes)
//                Build option:
//                  BOOTH_RADIX4_EN - radix-4 (modified Booth) recoding,
//                                    (WIDTH+2)/2 iterations instead of WIDTH+1
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_mul_seq #(
    parameter int WIDTH = 32
) (
    input  wire              clk,
    input  wire              rst,
    booth_mul_seq_if.slave   bus
);

`ifdef BOOTH_RADIX4_EN
    localparam int EXT   = WIDTH + 2;   // extended operand width
    localparam int N     = EXT / 2;     // iterations
    localparam int SH    = 2;           // shift per iteration
`else
    localparam int EXT   = WIDTH + 1;
    localparam int N     = EXT;
    localparam int SH    = 1;
`endif
    localparam int ACC_W = EXT + 1;                 // headroom for +/-2M
    localparam int TOT_W = ACC_W + EXT + 1;         // {acc, Q, q-1}
    localparam int CNT_W = $clog2(WIDTH + 2);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [ACC_W-1:0]  r_acc;
    logic [EXT-1:0]    r_m;
    logic [EXT-1:0]    r_q;
    logic              r_qm1;
    logic [CNT_W-1:0]  r_cnt;

    logic [EXT-1:0]           w_a_ext;
    logic [EXT-1:0]           w_b_ext;
    logic [ACC_W-1:0]         w_m_acc;
    logic [ACC_W-1:0]         w_sum;
    logic signed [TOT_W-1:0]  w_cat;
    logic signed [TOT_W-1:0]  w_shift;
    logic [ACC_W+EXT-1:0]     w_full;
    logic [ACC_W+EXT-2*WIDTH-1:0] w_unused_hi;

    // Extending by the sign bit only when signed lets a single signed
    // datapath produce exact results in both modes.
    assign w_a_ext = {{(EXT-WIDTH){bus.is_signed & bus.a[WIDTH-1]}}, bus.a};
    assign w_b_ext = {{(EXT-WIDTH){bus.is_signed & bus.b[WIDTH-1]}}, bus.b};
    assign w_m_acc = {{(ACC_W-EXT){r_m[EXT-1]}}, r_m};

`ifdef BOOTH_RADIX4_EN
    logic [ACC_W-1:0] w_m2;
    // The top bit dropped is a duplicate sign bit, so 2M keeps its sign.
    assign w_m2 = {w_m_acc[ACC_W-2:0], 1'b0};

    always_comb begin
        w_sum = r_acc;
        case ({r_q[1], r_q[0], r_qm1})
            3'b001, 3'b010: w_sum = r_acc + w_m_acc;
            3'b011:         w_sum = r_acc + w_m2;
            3'b100:         w_sum = r_acc - w_m2;
            3'b101, 3'b110: w_sum = r_acc - w_m_acc;
            default:        w_sum = r_acc;
        endcase
    end
`else
    always_comb begin
        w_sum = r_acc;
        case ({r_q[0], r_qm1})
            2'b01:   w_sum = r_acc + w_m_acc;
            2'b10:   w_sum = r_acc - w_m_acc;
            default: w_sum = r_acc;
        endcase
    end
`endif

    assign w_cat   = {w_sum, r_q, r_qm1};
    assign w_shift = w_cat >>> SH;

    // Low 2*WIDTH bits of the signed internal product; upper bits are only
    // sign copies.
    assign w_full      = {r_acc, r_q};
    assign bus.result  = w_full[2*WIDTH-1:0];
    assign w_unused_hi = w_full[ACC_W+EXT-1:2*WIDTH];

    assign bus.in_ready  = (r_state == c_IDLE);
    assign bus.out_valid = (r_state == c_DONE);
    assign bus.busy      = (r_state != c_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_acc   <= '0;
            r_m     <= '0;
            r_q     <= '0;
            r_qm1   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.in_valid) begin
                        r_m     <= w_a_ext;
                        r_q     <= w_b_ext;
                        r_acc   <= '0;
                        r_qm1   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_acc <= w_shift[TOT_W-1 -: ACC_W];
                    r_q   <= w_shift[EXT:1];
                    r_qm1 <= w_shift[0];
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(N - 1)) begin
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_booth_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_booth_mul_seq
//  Description : Self-checking bench for booth_mul_seq (WIDTH=32). Expected
//                products are queued at accept and popped at the output
//                handshake. Works with or without BOOTH_RADIX4_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_mul_seq;

    localparam int WIDTH = 32;
`ifdef BOOTH_RADIX4_EN
    localparam int N = (WIDTH + 2) / 2;
`else
    localparam int N = WIDTH + 1;
`endif
    localparam int LIMIT = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    booth_mul_seq_if #(.WIDTH(WIDTH)) bus ();

    booth_mul_seq #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa, sb;
        if (s) begin
            sa = $signed({{32{a[31]}}, a});
            sb = $signed({{32{b[31]}}, b});
            return 64'(sa * sb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    // One full transaction: accept, latency check, optional backpressure with
    // ignored in_valid pulses, output handshake and return to IDLE.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp, input int hold);
        int k;
        logic [63:0] held;
        chk("in_ready_idle", 64'(bus.in_ready), 64'd1);
        bus.a         = a;
        bus.b         = b;
        bus.is_signed = s;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        step();
        bus.in_valid = 1'b0;
        exp_q.push_back(exp);
        k = 0;
        while (!bus.out_valid && k < LIMIT) begin
            if (hold > 0) begin
                bus.in_valid = (k % 3 == 1);
                bus.a        = $urandom;
            end
            step();
            k++;
        end
        bus.in_valid = 1'b0;
        chk("latency", 64'(k), 64'(N));
        if (hold > 0) begin
            held = bus.result;
            for (int i = 0; i < hold; i++) begin
                bus.in_valid = (i % 2 == 0);
                step();
                chk("hold_valid", 64'(bus.out_valid), 64'd1);
                chk("hold_result", bus.result, held);
                chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        if (exp_q.size() == 0) begin
            chk("sb_empty", 64'd0, 64'd1);
        end else begin
            chk("result", bus.result, exp_q.pop_front());
        end
        step();
        chk("post_out_valid", 64'(bus.out_valid), 64'd0);
        chk("post_in_ready", 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        int k;
        logic seen;
        logic [31:0] ra, rb;
        logic rs;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.is_signed = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_result", bus.result, 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        run_op(32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F, 0);
        run_op(32'hFFFF_FFF9, 32'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, 0);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 0);
        run_op(32'h0, 32'h1234_5678, 1'b0, 64'h0, 0);
        run_op(32'h0, 32'h1234_5678, 1'b1, 64'h0, 0);
        run_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 64'hC000_0000_8000_0000, 0);

        // Backpressure
        run_op(32'h0001_2345, 32'hFFFF_0007, 1'b0, model(32'h0001_2345, 32'hFFFF_0007, 1'b0), 10);

        // Reset during RUN at iteration 10
        bus.a         = 32'h0000_7777;
        bus.b         = 32'h0000_1111;
        bus.is_signed = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 9; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < N + 5; i++) begin
            step();
            if (bus.out_valid) seen = 1'b1;
        end
        chk("abort_no_output", 64'(seen), 64'd0);
        run_op(32'd12, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFDC, 0);

        // Random mix in both modes
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'(i % 2);
            run_op(ra, rb, rs, model(ra, rb, rs), (i == 3) ? 2 : 0);
        end

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        k = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/booth_mul_seq.md
Name: booth_mul_seq

Overview:
Parametrised sequential Booth multiplier and the next generation of the team's 32-bit Booth multiplier. It adds selectable width, signed/unsigned operation per transaction, and valid/ready handshakes on both sides. It retires one Booth digit per clock. It sits beside the ALU as a multi-cycle functional unit: the issue logic feeds operands in, and writeback drains the full-width product.

Parameters:
WIDTH, 32, operand width in bits; must be even and at least 4.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  operand pair presented
in_ready  out  1  unit can accept operands (high only in IDLE)
a  in  WIDTH  multiplicand
b  in  WIDTH  multiplier
is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with a/b
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
result  out  2*WIDTH  product a*b
busy  out  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset: state goes to IDLE; out_valid=0, result=0, busy=0, in_ready=1 the cycle after the reset edge. Reset asserted mid-RUN or in DONE aborts the operation and discards the result with no output.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a, b and is_signed, then go to RUN.
  - RUN: one iteration per clock. After the last iteration, go to DONE.
  - DONE: out_valid=1 and result is held stable. On out_valid&&out_ready, go to IDLE.
  - No overlap: the next accept can occur at the earliest in the cycle after the output handshake.
- Operand extension: operands are extended internally to WIDTH+1 bits (is_signed: sign-extend; else zero-extend). This makes one datapath correct for both modes.
- Radix-2 recoding (default): examine {q0, q-1}, where q-1 is initialised to 0.
  - 01: add M.
  - 10: subtract M.
  - 00 or 11: no operation.
  - Then arithmetic-shift {acc, Q, q-1} right by 1.
  - N = WIDTH+1 iterations.
- Accumulator: acc is WIDTH+2 bits wide so the intermediate add/sub never overflows.
- Latency: for an accept edge T, iterations run on edges T+1..T+N. out_valid is high immediately after edge T+N. For WIDTH=32, that is 33 cycles from accept to out_valid.
- Result: result = low 2*WIDTH bits of the signed internal product. This value is exact for both signed and unsigned modes.
- Ignored inputs: in_valid is ignored outside IDLE. a, b and is_signed are don't-care outside the accept cycle.
- Hold stability: result must not change while out_valid=1 and out_ready=0.
- Zero-cycle hold: out_ready may be high on the first DONE cycle. In that case out_valid is high for exactly one cycle.
- Iteration counter: width is $clog2(WIDTH+2). It resets to 0 on accept. The last iteration is detected when the count reaches N-1. There is no wrap-around beyond N.

Optional Feature:
BOOTH_RADIX4_EN
- Defined: radix-4 (modified Booth) recoding.
  - Operands are extended to WIDTH+2 bits.
  - Each iteration examines the triplet {q1, q0, q-1}, selects one of 0, ±M, ±2M, then arithmetic-shifts right by 2.
  - N = (WIDTH+2)/2 iterations; 17 for WIDTH=32.
  - The accumulator is WIDTH+3 bits.
  - Handshake and result behaviour are otherwise identical.
- Undefined: radix-2 as described above, N = WIDTH+1.
- The bench reads latency through N and must pass in both builds.

Test Plan:
- Unsigned basic: WIDTH=32, is_signed=0, a=3, b=5, out_ready=1 → result=0x000000000000000F with out_valid exactly N cycles after the accept edge (33; 17 with BOOTH_RADIX4_EN).
- Signed mixed sign: is_signed=1, a=0xFFFFFFF9 (-7), b=6 → result=0xFFFFFFFFFFFFFFD6 (-42).
- Mode dependence: a=b=0xFFFFFFFF:
  - is_signed=0 → result=0xFFFFFFFE00000001.
  - is_signed=1 → result=0x0000000000000001.
- Extremes: is_signed=1, a=b=0x80000000 → result=0x4000000000000000. Also a=0, b=0x12345678 → 0 in both modes.
- Backpressure: out_ready held low 10 cycles after out_valid → result and out_valid stable, in_ready=0, in_valid pulses during RUN/DONE ignored. Raising out_ready gives one handshake, then in_ready=1 the next cycle.
- Reset mid-run: assert rst at iteration 10 → next cycle out_valid=0, busy=0, in_ready=1, and no result is ever emitted for the aborted operation. Then a=12, b=0xFFFFFFFD signed → result=0xFFFFFFFFFFFFFFDC (-36).
